// File: rtl/dataio_mem_responder_pkg.sv
// Shared definitions for the execute-stage data port responder.
package dataio_mem_responder_pkg;

  localparam int unsigned DATAIO_ADDR_W  = 32;
  localparam int unsigned DATAIO_DATA_W  = 32;
  localparam int unsigned DATAIO_BE_W    = 4;
  localparam int unsigned DATAIO_ORDER_W = 2;
  localparam int unsigned DATAIO_CNT_W   = 8;

  // Responder FSM state encodings
  typedef enum logic [2:0] {
    DATAIO_RSP_STT_IDLE  = 3'd0,
    DATAIO_RSP_STT_MREQ  = 3'd1,
    DATAIO_RSP_STT_MWAIT = 3'd2,
    DATAIO_RSP_STT_RESP  = 3'd3,
    DATAIO_RSP_STT_DRAIN = 3'd4
  } dataio_rsp_stt_t;

  // Access size codes from the LDST port
  typedef enum logic [DATAIO_ORDER_W-1:0] {
    DATAIO_ORDER_BYTE = 2'b00,
    DATAIO_ORDER_HALF = 2'b01,
    DATAIO_ORDER_WORD = 2'b10,
    DATAIO_ORDER_NONE = 2'b11
  } dataio_order_t;

  // Memory-bus command payload held for the duration of one access
  typedef struct packed {
    logic                     rw;
    logic [DATAIO_ADDR_W-1:0] addr;
    logic [DATAIO_BE_W-1:0]   be;
    logic [DATAIO_DATA_W-1:0] wdata;
  } dataio_mem_cmd_t;

endpackage

// File: rtl/dataio_be_check.sv
// Byte-enable generation and alignment/mode fault decode for one request.
module dataio_be_check
  import dataio_mem_responder_pkg::*;
(
  input  logic [DATAIO_ORDER_W-1:0] order,
  input  logic [1:0]                addr_lo,
  input  logic [1:0]                mmumod,
  output logic [DATAIO_BE_W-1:0]    be_c,
  output logic                      fault_c
);

  // Decode lane enables by size and flag misaligned, sizeless or mapped accesses
  always_comb begin
    be_c    = '0;
    fault_c = 1'b0;
    case (order)
      DATAIO_ORDER_BYTE: be_c = 4'b0001 << addr_lo;
      DATAIO_ORDER_HALF: begin
        be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        fault_c = addr_lo[0];
      end
      DATAIO_ORDER_WORD: begin
        be_c    = 4'b1111;
        fault_c = (addr_lo != 2'b00);
      end
      default: fault_c = 1'b1;
    endcase
    if (mmumod != 2'b00) fault_c = 1'b1;
  end

endmodule

// File: rtl/dataio_mem_responder.sv
// Single-outstanding load/store responder between the LDST port and the data memory bus.
module dataio_mem_responder
  import dataio_mem_responder_pkg::*;
#(
  parameter int unsigned P_TIMEOUT = 255
)(
  input  logic                      iCLOCK,
  input  logic                      inRESET,
  input  logic                      iRESET_SYNC,
  input  logic                      iCORE_REQ,
  output logic                      oCORE_BUSY,
  input  logic [DATAIO_ORDER_W-1:0] iCORE_ORDER,
  input  logic [3:0]                iCORE_MASK,
  input  logic                      iCORE_RW,
  input  logic [13:0]               iCORE_TID,
  input  logic [1:0]                iCORE_MMUMOD,
  input  logic [31:0]               iCORE_PDT,
  input  logic [DATAIO_ADDR_W-1:0]  iCORE_ADDR,
  input  logic [DATAIO_DATA_W-1:0]  iCORE_DATA,
  output logic                      oCORE_VALID,
  output logic [DATAIO_DATA_W-1:0]  oCORE_DATA,
  output logic                      oCORE_FAULT,
  output logic                      oMEM_REQ,
  input  logic                      iMEM_ACK,
  output logic                      oMEM_RW,
  output logic [DATAIO_ADDR_W-1:0]  oMEM_ADDR,
  output logic [DATAIO_BE_W-1:0]    oMEM_BE,
  output logic [DATAIO_DATA_W-1:0]  oMEM_WDATA,
  input  logic                      iMEM_VALID,
  input  logic [DATAIO_DATA_W-1:0]  iMEM_RDATA
);

  dataio_rsp_stt_t            state_q, state_nxt;
  dataio_mem_cmd_t            cmd_q, cmd_nxt;
  logic [DATAIO_DATA_W-1:0]   rdata_q, rdata_nxt;
  logic                       fault_q, fault_nxt;
  logic                       tout_q, tout_nxt;
  logic [DATAIO_CNT_W-1:0]    cnt_q, cnt_nxt, cnt_inc;
  logic [DATAIO_BE_W-1:0]     be_c;
  logic                       req_fault_c;

  // Initiator sideband carried on the port but not needed by this responder
  logic unused_core_sideband;
  assign unused_core_sideband = ^{iCORE_MASK, iCORE_TID, iCORE_PDT};

  dataio_be_check u_be_check (
    .order   (iCORE_ORDER),
    .addr_lo (iCORE_ADDR[1:0]),
    .mmumod  (iCORE_MMUMOD),
    .be_c    (be_c),
    .fault_c (req_fault_c)
  );

  assign cnt_inc    = cnt_q + DATAIO_CNT_W'(1);
  assign oMEM_RW    = cmd_q.rw;
  assign oMEM_ADDR  = cmd_q.addr;
  assign oMEM_BE    = cmd_q.be;
  assign oMEM_WDATA = cmd_q.wdata;

  // Next-state, latch updates and memory-wait watchdog
  always_comb begin
    state_nxt = state_q;
    cmd_nxt   = cmd_q;
    rdata_nxt = rdata_q;
    fault_nxt = fault_q;
    tout_nxt  = tout_q;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      DATAIO_RSP_STT_IDLE: begin
        if (!iRESET_SYNC && iCORE_REQ) begin
          cmd_nxt.rw    = iCORE_RW;
          cmd_nxt.addr  = {iCORE_ADDR[DATAIO_ADDR_W-1:2], 2'b00};
          cmd_nxt.be    = be_c;
          cmd_nxt.wdata = iCORE_DATA;
          rdata_nxt     = '0;
          fault_nxt     = req_fault_c;
          tout_nxt      = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = req_fault_c ? DATAIO_RSP_STT_RESP : DATAIO_RSP_STT_MREQ;
        end
      end
      DATAIO_RSP_STT_MREQ: begin
        if (iRESET_SYNC) begin
          state_nxt = DATAIO_RSP_STT_IDLE;
        end else if (iMEM_ACK) begin
          cnt_nxt = '0;
          if (iMEM_VALID) begin
            rdata_nxt = cmd_q.rw ? '0 : iMEM_RDATA;
            state_nxt = DATAIO_RSP_STT_RESP;
          end else begin
            state_nxt = DATAIO_RSP_STT_MWAIT;
          end
        end
      end
      DATAIO_RSP_STT_MWAIT: begin
        if (iRESET_SYNC) begin
          state_nxt = DATAIO_RSP_STT_DRAIN;
        end else if (iMEM_VALID) begin
          rdata_nxt = cmd_q.rw ? '0 : iMEM_RDATA;
          state_nxt = DATAIO_RSP_STT_RESP;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == DATAIO_CNT_W'(P_TIMEOUT)) begin
            rdata_nxt = '0;
            fault_nxt = 1'b1;
            tout_nxt  = 1'b1;
            state_nxt = DATAIO_RSP_STT_RESP;
          end
        end
      end
      DATAIO_RSP_STT_RESP: begin
        if (iRESET_SYNC)  state_nxt = DATAIO_RSP_STT_IDLE;
        else if (tout_q)  state_nxt = DATAIO_RSP_STT_DRAIN;
        else              state_nxt = DATAIO_RSP_STT_IDLE;
      end
      DATAIO_RSP_STT_DRAIN: begin
        // A late completion is swallowed so it cannot pair with the next request
        if (iMEM_VALID) state_nxt = DATAIO_RSP_STT_IDLE;
      end
      default: state_nxt = DATAIO_RSP_STT_IDLE;
    endcase
  end

  // State, latches and registered core-side outputs
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q     <= DATAIO_RSP_STT_IDLE;
      cmd_q       <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      tout_q      <= 1'b0;
      cnt_q       <= '0;
      oCORE_BUSY  <= 1'b0;
      oMEM_REQ    <= 1'b0;
      oCORE_VALID <= 1'b0;
      oCORE_DATA  <= '0;
      oCORE_FAULT <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cmd_q       <= cmd_nxt;
      rdata_q     <= rdata_nxt;
      fault_q     <= fault_nxt;
      tout_q      <= tout_nxt;
      cnt_q       <= cnt_nxt;
      oCORE_BUSY  <= (state_nxt != DATAIO_RSP_STT_IDLE);
      oMEM_REQ    <= (state_nxt == DATAIO_RSP_STT_MREQ);
      oCORE_VALID <= (state_nxt == DATAIO_RSP_STT_RESP);
      oCORE_DATA  <= (state_nxt == DATAIO_RSP_STT_RESP) ? rdata_nxt : '0;
      oCORE_FAULT <= (state_nxt == DATAIO_RSP_STT_RESP) && fault_nxt;
    end
  end

endmodule
